// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data SRAM responder: FSM encoding and latency bounds.
package data_sram_responder_pkg;

    typedef enum logic [1:0] {
        DSR_IDLE = 2'd0,
        DSR_WAIT = 2'd1,
        DSR_RESP = 2'd2
    } dsr_state_e;

    // The countdown register is 4 bits wide, which bounds LATENCY to 1..15.
    localparam int DSR_LAT_MIN = 1;
    localparam int DSR_LAT_MAX = 15;
    localparam int DSR_CNT_W   = 4;

endpackage

// File: rtl/data_sram_responder_bram.sv
// Single-port word RAM with synchronous read and per-byte write enables.
// Only the read register is reset; the array keeps its contents across reset.
module bram_be #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // A store leaves the read register untouched so the last load result persists.
    always_comb begin
        rdata_d = rdata_q;
        if (en && (we == 4'b0000)) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'h0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Fixed-latency responder for the CPU data SRAM port: stalls the pipeline for LATENCY
// cycles per access, then presents one RESP cycle (held while longest_stall is high).
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    input  logic        longest_stall,
    output logic [31:0] data_sram_rdata,
    output logic        d_stall,
    output logic        addr_err
);

    localparam logic [DSR_CNT_W-1:0] CNT_INIT = DSR_CNT_W'(LATENCY - 1);

    dsr_state_e           state_q, state_d;
    logic [DSR_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic                 oor_q, oor_d;
    logic [3:0]           wen_q, wen_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 addr_err_q, addr_err_d;
    logic                 rd_zero_q, rd_zero_d;

    logic              fire;
    logic [ADDR_W-1:0] acc_idx;
    logic              acc_oor;
    logic [3:0]        acc_wen;
    logic [31:0]       acc_wdata;
    logic              ram_en;
    logic [31:0]       ram_rdata;

    logic [ADDR_W-1:0] in_idx;
    logic              in_oor;
    logic [1:0]        unused_addr_lsb;

    // Byte-offset bits are ignored; misalignment is trapped before this block.
    assign in_idx          = data_sram_addr[ADDR_W+1:2];
    assign in_oor          = |data_sram_addr[31:ADDR_W+2];
    assign unused_addr_lsb = data_sram_addr[1:0];

    // fire marks the cycle whose clock edge enters RESP; the RAM access happens on that edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        oor_d      = oor_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        addr_err_d = 1'b0;
        rd_zero_d  = rd_zero_q;
        fire       = 1'b0;
        acc_idx    = idx_q;
        acc_oor    = oor_q;
        acc_wen    = wen_q;
        acc_wdata  = wdata_q;

        case (state_q)
            DSR_IDLE: begin
                if (data_sram_en) begin
                    idx_d   = in_idx;
                    oor_d   = in_oor;
                    wen_d   = data_sram_wen;
                    wdata_d = data_sram_wdata;
                    cnt_d   = CNT_INIT;
                    if (LATENCY > 1) begin
                        state_d = DSR_WAIT;
                    end else begin
                        state_d   = DSR_RESP;
                        fire      = 1'b1;
                        acc_idx   = in_idx;
                        acc_oor   = in_oor;
                        acc_wen   = data_sram_wen;
                        acc_wdata = data_sram_wdata;
                    end
                end
            end
            DSR_WAIT: begin
                cnt_d = cnt_q - DSR_CNT_W'(1);
                if (cnt_q == DSR_CNT_W'(1)) begin
                    state_d = DSR_RESP;
                    fire    = 1'b1;
                end
            end
            DSR_RESP: begin
                if (!longest_stall) begin
                    state_d = DSR_IDLE;
                end
            end
            default: state_d = DSR_IDLE;
        endcase

        if (fire) begin
            addr_err_d = acc_oor;
            if (acc_wen == 4'b0000) begin
                rd_zero_d = acc_oor;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DSR_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            oor_q      <= 1'b0;
            wen_q      <= 4'b0000;
            wdata_q    <= 32'h0;
            addr_err_q <= 1'b0;
            rd_zero_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            oor_q      <= oor_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            addr_err_q <= addr_err_d;
            rd_zero_q  <= rd_zero_d;
        end
    end

    // Reset suppresses the access so an aborted store never lands in the RAM.
    assign ram_en = fire && !acc_oor && !rst;

    bram_be #(
        .ADDR_W(ADDR_W)
    ) u_bram (
        .clk  (clk),
        .rst  (rst),
        .en   (ram_en),
        .we   (acc_wen),
        .addr (acc_idx),
        .wdata(acc_wdata),
        .rdata(ram_rdata)
    );

    assign data_sram_rdata = rd_zero_q ? 32'h0 : ram_rdata;
    assign d_stall  = !rst && (((state_q == DSR_IDLE) && data_sram_en) || (state_q == DSR_WAIT));
    assign addr_err = addr_err_q;

endmodule
